// File: rtl/hd44780_init_seq_pkg.sv
// Shared hd44780 build/sim configuration (timer width, delay tick counts) and the
// step-table encoding used by the power-on init sequencer.
`ifndef H4_SYSFREQ
`define H4_SYSFREQ 50000000
`endif
`ifndef H4_TIMER_BITS
`define H4_TIMER_BITS 24
`endif
`ifndef H4_DELAY_100MS
`define H4_DELAY_100MS 5000000
`endif
`ifndef H4_DELAY_4P1MS
`define H4_DELAY_4P1MS 205000
`endif
`ifndef H4_DELAY_3MS
`define H4_DELAY_3MS 150000
`endif
`ifndef H4_DELAY_100US
`define H4_DELAY_100US 5000
`endif
`ifndef H4_DELAY_53US
`define H4_DELAY_53US 2650
`endif

package hd44780_init_seq_pkg;

   typedef enum logic [1:0] {
      STEP_DELAY = 2'd0,
      STEP_NYB   = 2'd1,
      STEP_END   = 2'd2
   } step_kind_t;

   // A DELAY step carries one of these selectors in its argument field.
   typedef enum logic [2:0] {
      DLY_100MS = 3'd0,
      DLY_4P1MS = 3'd1,
      DLY_3MS   = 3'd2,
      DLY_100US = 3'd3,
      DLY_53US  = 3'd4
   } delay_sel_t;

   typedef struct packed {
      step_kind_t kind;
      logic [3:0] arg;
   } step_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAIT_TMR = 3'd2,
      ST_WAIT_NYB = 3'd3,
      ST_FINISH   = 3'd4
   } init_state_t;

   localparam int STEP_IDX_BITS = 5;
   localparam logic [STEP_IDX_BITS-1:0] LAST_STEP = 5'd24;

   function automatic step_t step_delay(input delay_sel_t sel);
      step_t s;
      s.kind = STEP_DELAY;
      s.arg  = {1'b0, sel};
      return s;
   endfunction

   function automatic step_t step_nyb(input logic [3:0] nyb);
      step_t s;
      s.kind = STEP_NYB;
      s.arg  = nyb;
      return s;
   endfunction

   function automatic step_t step_end();
      step_t s;
      s.kind = STEP_END;
      s.arg  = 4'h0;
      return s;
   endfunction

endpackage

// File: rtl/hd44780_init_seq.sv
// HD44780 power-on initialisation sequencer: walks a fixed step table, handing
// delays to the sibling state timer and command nybbles to the sibling nybble sender.
module hd44780_init_seq
   import hd44780_init_seq_pkg::*;
#(
   parameter int SYSFREQ          = `H4_SYSFREQ,
   parameter int STATE_TIMER_BITS = `H4_TIMER_BITS,
   parameter int D100MS           = `H4_DELAY_100MS,
   parameter int D4P1MS           = `H4_DELAY_4P1MS,
   parameter int D3MS             = `H4_DELAY_3MS,
   parameter int D100US           = `H4_DELAY_100US,
   parameter int D53US            = `H4_DELAY_53US
) (
   input  logic                        CLK_I,
   input  logic                        RST_I,
   input  logic                        start,
   output logic [STATE_TIMER_BITS-1:0] tmr_dat,
   output logic                        tmr_start,
   input  logic                        tmr_end,
   output logic [3:0]                  nyb_dat,
   output logic                        nyb_rs,
   output logic                        nyb_start,
   input  logic                        nyb_done,
   output logic                        busy,
   output logic                        done,
   output logic                        ready
);

   localparam longint TMR_LIMIT = longint'(1) << STATE_TIMER_BITS;

   // Catch a config include whose delays do not fit the timer load width.
   if (SYSFREQ <= 0) begin : g_bad_sysfreq
      $error("hd44780_init_seq: SYSFREQ must be positive");
   end
   if (longint'(D100MS) >= TMR_LIMIT || longint'(D4P1MS) >= TMR_LIMIT ||
       longint'(D3MS) >= TMR_LIMIT || longint'(D100US) >= TMR_LIMIT ||
       longint'(D53US) >= TMR_LIMIT) begin : g_bad_delay
      $error("hd44780_init_seq: a delay constant exceeds STATE_TIMER_BITS");
   end

   function automatic step_t step_rom(input logic [STEP_IDX_BITS-1:0] idx);
      case (idx)
         5'd0:    return step_delay(DLY_100MS);
         5'd1:    return step_nyb(4'h3);
         5'd2:    return step_delay(DLY_4P1MS);
         5'd3:    return step_nyb(4'h3);
         5'd4:    return step_delay(DLY_100US);
         5'd5:    return step_nyb(4'h3);
         5'd6:    return step_delay(DLY_100US);
         5'd7:    return step_nyb(4'h2);
         5'd8:    return step_delay(DLY_100US);
         5'd9:    return step_nyb(4'h2);
         5'd10:   return step_nyb(4'h8);
         5'd11:   return step_delay(DLY_53US);
         5'd12:   return step_nyb(4'h0);
         5'd13:   return step_nyb(4'h8);
         5'd14:   return step_delay(DLY_53US);
         5'd15:   return step_nyb(4'h0);
         5'd16:   return step_nyb(4'h1);
         5'd17:   return step_delay(DLY_3MS);
         5'd18:   return step_nyb(4'h0);
         5'd19:   return step_nyb(4'h6);
         5'd20:   return step_delay(DLY_53US);
         5'd21:   return step_nyb(4'h0);
         5'd22:   return step_nyb(4'hC);
         5'd23:   return step_delay(DLY_53US);
         5'd24:   return step_end();
         default: return step_end();
      endcase
   endfunction

   function automatic logic [STATE_TIMER_BITS-1:0] delay_ticks(input logic [2:0] sel);
      case (sel)
         DLY_100MS: return STATE_TIMER_BITS'(D100MS);
         DLY_4P1MS: return STATE_TIMER_BITS'(D4P1MS);
         DLY_3MS:   return STATE_TIMER_BITS'(D3MS);
         DLY_100US: return STATE_TIMER_BITS'(D100US);
         DLY_53US:  return STATE_TIMER_BITS'(D53US);
         default:   return '0;
      endcase
   endfunction

   init_state_t                 state_reg;
   logic [STEP_IDX_BITS-1:0]    idx_reg;
   logic [STEP_IDX_BITS-1:0]    idx_next;
   logic [STATE_TIMER_BITS-1:0] tmr_dat_reg;
   logic                        tmr_start_reg;
   logic [3:0]                  nyb_dat_reg;
   logic                        nyb_start_reg;
   logic                        busy_reg;
   logic                        done_reg;
   logic                        ready_reg;
   step_t                       cur_step;

   always_comb begin
      cur_step = step_rom(idx_reg);
      // Saturate at the END entry so the index can never run past the table.
      idx_next = (idx_reg == LAST_STEP) ? idx_reg : idx_reg + STEP_IDX_BITS'(1);
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         tmr_dat_reg   <= '0;
         tmr_start_reg <= 1'b0;
         nyb_dat_reg   <= '0;
         nyb_start_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         ready_reg     <= 1'b0;
      end else begin
         tmr_start_reg <= 1'b0;
         nyb_start_reg <= 1'b0;
         done_reg      <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  idx_reg   <= '0;
                  busy_reg  <= 1'b1;
                  ready_reg <= 1'b0;
                  state_reg <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // Data registers are only rewritten here, so they hold until the ack.
               case (cur_step.kind)
                  STEP_DELAY: begin
                     tmr_dat_reg   <= delay_ticks(cur_step.arg[2:0]);
                     tmr_start_reg <= 1'b1;
                     state_reg     <= ST_WAIT_TMR;
                  end
                  STEP_NYB: begin
                     nyb_dat_reg   <= cur_step.arg;
                     nyb_start_reg <= 1'b1;
                     state_reg     <= ST_WAIT_NYB;
                  end
                  default: state_reg <= ST_FINISH;
               endcase
            end
            ST_WAIT_TMR: begin
               if (tmr_end) begin
                  idx_reg   <= idx_next;
                  state_reg <= ST_FETCH;
               end
            end
            ST_WAIT_NYB: begin
               if (nyb_done) begin
                  idx_reg   <= idx_next;
                  state_reg <= ST_FETCH;
               end
            end
            ST_FINISH: begin
               done_reg  <= 1'b1;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign tmr_dat   = tmr_dat_reg;
   assign tmr_start = tmr_start_reg;
   assign nyb_dat   = nyb_dat_reg;
   assign nyb_rs    = 1'b0;
   assign nyb_start = nyb_start_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign ready     = ready_reg;

endmodule

// File: tb/tb_hd44780_init_seq.sv
// Scoreboard bench for hd44780_init_seq with auto-responding timer and nybble-sender models
// that answer after random delays.
module tb_hd44780_init_seq;

   localparam int          TW     = `H4_TIMER_BITS;
   localparam int unsigned P100MS = `H4_DELAY_100MS;
   localparam int unsigned P4P1MS = `H4_DELAY_4P1MS;
   localparam int unsigned P3MS   = `H4_DELAY_3MS;
   localparam int unsigned P100US = `H4_DELAY_100US;
   localparam int unsigned P53US  = `H4_DELAY_53US;

   // Reference init table: kind 0 = delay, 1 = nybble, 2 = end.
   localparam int REF_KIND [25] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1,
                                    1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 2};
   localparam int unsigned REF_VAL [25] = '{P100MS, 3, P4P1MS, 3, P100US, 3, P100US, 2,
                                            P100US, 2, 8, P53US, 0, 8, P53US, 0, 1, P3MS,
                                            0, 6, P53US, 0, 12, P53US, 0};

   typedef struct {
      int          kind;
      int unsigned val;
      int          step;
   } ev_t;

   logic          CLK_I = 1'b0;
   logic          RST_I = 1'b1;
   logic          start = 1'b0;
   logic          tmr_end = 1'b0;
   logic          nyb_done = 1'b0;
   logic [TW-1:0] tmr_dat;
   logic          tmr_start;
   logic [3:0]    nyb_dat;
   logic          nyb_rs;
   logic          nyb_start;
   logic          busy;
   logic          done;
   logic          ready;

   hd44780_init_seq dut (
      .CLK_I     (CLK_I),
      .RST_I     (RST_I),
      .start     (start),
      .tmr_dat   (tmr_dat),
      .tmr_start (tmr_start),
      .tmr_end   (tmr_end),
      .nyb_dat   (nyb_dat),
      .nyb_rs    (nyb_rs),
      .nyb_start (nyb_start),
      .nyb_done  (nyb_done),
      .busy      (busy),
      .done      (done),
      .ready     (ready)
   );

   always #5 CLK_I = ~CLK_I;

   int  cyc = 0;
   always @(posedge CLK_I) cyc <= cyc + 1;

   int  n_checks = 0;
   int  n_fail = 0;
   ev_t exp_q[$];
   int  tmr_cnt = 0, nyb_cnt = 0, done_cnt = 0, spur_cnt = 0;
   int  last_ack_cyc = 0;
   bit  hold_nyb = 1'b0;
   bit  spur_req = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_checks++;
      n_fail++;
      $display("FAIL %s: %s (cyc %0d)", name, what, cyc);
   endtask

   task automatic sb_pop(input int kind, input logic [63:0] val);
      ev_t e;
      if (exp_q.size() == 0) begin
         fail_now("sb_unexpected", $sformatf("kind %0d value %0d, required no output", kind, val));
      end else begin
         e = exp_q.pop_front();
         check($sformatf("sb_kind_step%0d", e.step), 64'(kind), 64'(e.kind));
         if (e.kind != 2) check($sformatf("sb_value_step%0d", e.step), val, 64'(e.val));
         if (kind != 2 && e.step != 0)
            check($sformatf("ack_to_strobe_latency_step%0d", e.step), 64'(cyc - last_ack_cyc), 64'd2);
         $display("[cyc %0d] step %0d kind %0d value %0d", cyc, e.step, kind, val);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT issues a strobe or completes.
   initial begin
      forever begin
         @(negedge CLK_I);
         if (!RST_I) begin
            if (tmr_start) begin
               tmr_cnt++;
               check("excl_strobe", nyb_start, 0);
               check("busy_at_tmr_start", busy, 1);
               sb_pop(0, 64'(tmr_dat));
            end
            if (nyb_start) begin
               nyb_cnt++;
               check("nyb_rs", nyb_rs, 0);
               sb_pop(1, 64'(nyb_dat));
            end
            if (done) begin
               done_cnt++;
               check("ready_at_done", ready, 1);
               check("busy_at_done", busy, 0);
               sb_pop(2, 0);
            end
         end
      end
   end

   // Timer and nybble-sender models.
   initial begin
      bit tmr_pend = 0, nyb_pend = 0;
      int tmr_wait = 0, nyb_wait = 0;
      forever begin
         @(negedge CLK_I);
         tmr_end  = 1'b0;
         nyb_done = 1'b0;
         if (RST_I) begin
            tmr_pend = 0;
            nyb_pend = 0;
         end else begin
            if (tmr_start) begin
               tmr_pend = 1;
               tmr_wait = int'($urandom_range(1, 6));
            end else if (tmr_pend) begin
               tmr_wait--;
               if (tmr_wait == 0) begin
                  tmr_end = 1'b1;
                  tmr_pend = 0;
                  last_ack_cyc = cyc;
               end
            end
            if (nyb_start) begin
               nyb_pend = 1;
               nyb_wait = int'($urandom_range(3, 6));
            end else if (nyb_pend && !hold_nyb) begin
               nyb_wait--;
               if (nyb_wait == 0) begin
                  nyb_done = 1'b1;
                  nyb_pend = 0;
                  last_ack_cyc = cyc;
               end
            end
            if (spur_req && nyb_pend) begin
               tmr_end = 1'b1;
               spur_req = 1'b0;
               spur_cnt++;
            end
         end
      end
   end

   task automatic wait_nyb_start(output bit ok);
      ok = 0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge CLK_I);
         if (nyb_start) ok = 1;
      end
      if (!ok) fail_now("wait_nyb_start", "timeout");
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tmr_dat"}, 64'(tmr_dat), 0);
      check({tag, "_tmr_start"}, tmr_start, 0);
      check({tag, "_nyb_dat"}, 64'(nyb_dat), 0);
      check({tag, "_nyb_rs"}, nyb_rs, 0);
      check({tag, "_nyb_start"}, nyb_start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ready"}, ready, 0);
   endtask

   // mode 0: plain, 1: held nybble ack + mid-run start, 2: spurious tmr_end, 3: reset at step 17
   task automatic run_seq(input int mode);
      int  t0, n0, d0, s0, rep, chg;
      bit  ok;
      logic [3:0] cap;
      ev_t e;
      t0 = tmr_cnt; n0 = nyb_cnt; d0 = done_cnt; s0 = spur_cnt;
      hold_nyb = (mode == 1);
      repeat ($urandom_range(1, 10)) @(negedge CLK_I);
      for (int i = 0; i < 25; i++) begin
         e.kind = REF_KIND[i];
         e.val  = REF_VAL[i];
         e.step = i;
         exp_q.push_back(e);
      end
      start = 1'b1;
      @(negedge CLK_I);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("ready_after_start", ready, 0);
      ok = 0;
      for (int c = 0; c < 10 && !ok; c++) begin
         if (tmr_start) ok = 1;
         else @(negedge CLK_I);
      end
      if (!ok) fail_now("first_tmr_start", "timeout");
      else begin
         check("first_tmr_dat", 64'(tmr_dat), 64'(P100MS));
         check("first_busy", busy, 1);
      end

      if (mode == 1) begin
         wait_nyb_start(ok);
         cap = nyb_dat;
         rep = 0; chg = 0;
         for (int c = 0; c < 50; c++) begin
            @(negedge CLK_I);
            if (nyb_start) rep++;
            if (nyb_dat !== cap) chg++;
         end
         check("hold_nyb_start_repeats", 64'(rep), 0);
         check("hold_nyb_dat_changes", 64'(chg), 0);
         check("hold_busy", busy, 1);
         start = 1'b1;
         @(negedge CLK_I);
         start = 1'b0;
         hold_nyb = 1'b0;
      end else if (mode == 2) begin
         for (int k = 0; k < 3; k++) begin
            wait_nyb_start(ok);
            spur_req = 1'b1;
         end
      end else if (mode == 3) begin
         ok = 0;
         for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge CLK_I);
            if (tmr_start && tmr_dat == TW'(P3MS)) ok = 1;
         end
         if (!ok) fail_now("wait_step17", "timeout");
         @(negedge CLK_I);
         RST_I = 1'b1;
         exp_q.delete();
         @(negedge CLK_I);
         check_all_zero("midwait_reset");
         RST_I = 1'b0;
         t0 = tmr_cnt; n0 = nyb_cnt;
         repeat (20) @(negedge CLK_I);
         check("no_autorestart_busy", busy, 0);
         check("no_autorestart_strobes", 64'((tmr_cnt - t0) + (nyb_cnt - n0)), 0);
         return;
      end

      ok = 0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(negedge CLK_I);
         if (done_cnt > d0) ok = 1;
      end
      if (!ok) fail_now("wait_done", "timeout");
      repeat (3) @(negedge CLK_I);
      check("run_tmr_strobes", 64'(tmr_cnt - t0), 10);
      check("run_nyb_strobes", 64'(nyb_cnt - n0), 14);
      check("run_done_pulses", 64'(done_cnt - d0), 1);
      check("run_ready", ready, 1);
      check("run_busy", busy, 0);
      check("run_sb_empty", 64'(exp_q.size()), 0);
      if (mode == 2) check("spurious_injected", 64'(spur_cnt - s0), 3);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CLK_I);
      check_all_zero("reset");
      RST_I = 1'b0;
      repeat (5) @(negedge CLK_I);
      check("idle_no_start_busy", busy, 0);
      run_seq(0);
      run_seq(1);
      run_seq(2);
      run_seq(3);
      run_seq(0);
      run_seq(0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
